spm_serial_seq: RTL and testbench

- Sequencer wrapped around the serial-parallel multiplier (spm) array.
- Accepts a parallel operand pair over a valid/ready handshake and holds the multiplicand x stable on the array's parallel input.
- Streams multiplier y LSB-first into the array's serial input and deserialises the array's serial product bit stream into one 2*WIDTH-bit result.
- Sits directly upstream (y/x feed) and downstream (product collection) of the per-bit carry-save stages.

---
 rtl/spm_serial_seq.sv | 100 ++++++++++
 tb/tb_spm_serial_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spm_serial_seq.sv
// rtl/spm_serial_seq.sv - operand sequencer and product deserialiser for the serial-parallel multiplier array
module spm_serial_seq #(
    parameter int WIDTH   = 32,
    parameter int SPM_LAT = 1,
    parameter bit SIGNED  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_y,
    output logic [WIDTH-1:0]     spm_x,
    output logic                 spm_y,
    output logic                 spm_clr,
    input  logic                 spm_p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod
);
    localparam int RUN_CYCLES = 2*WIDTH + SPM_LAT;
    localparam int CW = $clog2(RUN_CYCLES + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RUN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic [WIDTH-1:0] y_reg;
    logic             cap_en;

    // Multiplier bit presented during RUN count n: y itself, then its extension, then zeros
    function automatic logic y_bit(input logic [WIDTH-1:0] y, input logic [CW-1:0] n);
        if (int'(n) < WIDTH)
            return y[n[IW-1:0]];
        else if (int'(n) < 2*WIDTH)
            return SIGNED & y[WIDTH-1];
        else
            return 1'b0;
    endfunction

    assign cnt_next = cnt + CW'(1);
    assign cap_en   = (int'(cnt) >= SPM_LAT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            y_reg     <= '0;
            spm_x     <= '0;
            spm_y     <= 1'b0;
            spm_clr   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_prod  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        spm_x    <= in_x;
                        y_reg    <= in_y;
                        spm_clr  <= 1'b1;
                        spm_y    <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    spm_clr <= 1'b0;
                    cnt     <= '0;
                    spm_y   <= y_bit(y_reg, '0);
                    state   <= RUN;
                end
                RUN: begin
                    // Product bits arrive SPM_LAT cycles behind their y bit; shift in at the MSB
                    if (cap_en)
                        out_prod <= {spm_p, out_prod[2*WIDTH-1:1]};
                    if (cnt == CNT_LAST) begin
                        spm_y     <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt   <= cnt_next;
                        spm_y <= y_bit(y_reg, cnt_next);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spm_serial_seq.sv
// tb/tb_spm_serial_seq.sv - scoreboard bench for spm_serial_seq with behavioural spm arrays
module tb_spm_serial_seq;
    localparam int W       = 8;
    localparam int LAT     = 1;
    localparam int LATENCY = 2*W + LAT + 2;
    localparam int PERIOD  = 2*W + LAT + 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         in_valid = 1'b0, in_ready, spm_y, spm_clr, spm_p, out_valid, out_ready = 1'b1;
    logic [W-1:0] in_x = '0, in_y = '0, spm_x;
    logic [2*W-1:0] out_prod;

    logic         u_in_valid = 1'b0, u_in_ready, u_spm_y, u_spm_clr, u_spm_p, u_out_valid;
    logic         u_out_ready = 1'b1;
    logic [W-1:0] u_in_x = '0, u_in_y = '0, u_spm_x;
    logic [2*W-1:0] u_out_prod;

    spm_serial_seq #(.WIDTH(W), .SPM_LAT(LAT), .SIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .spm_x(spm_x), .spm_y(spm_y), .spm_clr(spm_clr), .spm_p(spm_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod));

    spm_serial_seq #(.WIDTH(W), .SPM_LAT(LAT), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(u_in_valid), .in_ready(u_in_ready), .in_x(u_in_x), .in_y(u_in_y),
        .spm_x(u_spm_x), .spm_y(u_spm_y), .spm_clr(u_spm_clr), .spm_p(u_spm_p),
        .out_valid(u_out_valid), .out_ready(u_out_ready), .out_prod(u_out_prod));

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string msg);
        n_total++;
        $display("FAIL %s", msg);
    endtask

    // Array model: accumulate y_bit*x*2^k, emit bit k one cycle later
    longint s_acc; int s_k;
    always @(posedge clk) begin : sarr
        longint nacc;
        if (!rst || spm_clr) begin
            s_acc <= 0; s_k <= 0; spm_p <= 1'b0;
        end else begin
            nacc = s_acc + (spm_y ? (longint'($signed(spm_x)) <<< s_k) : 64'sd0);
            s_acc <= nacc;
            spm_p <= nacc[s_k];
            if (s_k < 63) s_k <= s_k + 1;
        end
    end

    longint u_acc; int u_k;
    always @(posedge clk) begin : uarr
        longint nacc;
        if (!rst || u_spm_clr) begin
            u_acc <= 0; u_k <= 0; u_spm_p <= 1'b0;
        end else begin
            nacc = u_acc + (u_spm_y ? (longint'(u_spm_x) <<< u_k) : 64'sd0);
            u_acc <= nacc;
            u_spm_p <= nacc[u_k];
            if (u_k < 63) u_k <= u_k + 1;
        end
    end

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        return 16'(longint'($signed(x)) * longint'($signed(y)));
    endfunction

    function automatic logic [2*W-1:0] ref_mul_u(input logic [W-1:0] x, input logic [W-1:0] y);
        return 16'(longint'(x) * longint'(y));
    endfunction

    logic [2*W-1:0] exp_q[$];
    int             hs_q[$];
    logic           prev_hs = 1'b0, prev_ov = 1'b0, prev_acc = 1'b0, busy = 1'b0;
    logic [2*W-1:0] prev_prod = '0;
    int             acc_cyc = -100;

    // Monitor: handshake bookkeeping, protocol checks and product scoreboard
    always @(negedge clk) begin : mon
        logic hs, acc;
        if (!rst) begin
            exp_q.delete(); hs_q.delete();
            busy = 1'b0; prev_hs = 1'b0; prev_ov = 1'b0; prev_acc = 1'b0;
        end else begin
            hs  = in_valid && in_ready;
            acc = out_valid && out_ready;
            if (spm_clr || prev_hs) check("spm_clr_pulse", spm_clr, prev_hs);
            check("in_ready_busy", in_ready, !busy);
            if (prev_ov && !prev_acc) begin
                check("stall_valid", out_valid, 1);
                check("stall_prod", out_prod, prev_prod);
            end
            if (prev_acc) check("valid_drop", out_valid, 0);
            if (out_valid && !prev_ov) begin
                if (hs_q.size() > 0) check("latency", cyc - hs_q.pop_front(), LATENCY);
                else fail("out_valid without handshake");
            end
            if (acc) begin
                if (exp_q.size() > 0) check("product", out_prod, exp_q.pop_front());
                else fail("unexpected product");
                acc_cyc = cyc;
                busy = 1'b0;
            end
            if (hs) begin
                hs_q.push_back(cyc);
                busy = 1'b1;
            end
            prev_hs = hs; prev_ov = out_valid; prev_acc = acc; prev_prod = out_prod;
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, output int hc);
        int t;
        hc = -1;
        t = 0;
        @(negedge clk);
        in_x = x; in_y = y; in_valid = 1'b1;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            fail("handshake timeout");
            in_valid = 1'b0;
            return;
        end
        hc = cyc;
        @(posedge clk);
        exp_q.push_back(ref_mul(x, y));
        #1;
        in_valid = 1'b0;
        in_x = W'($urandom);
        in_y = W'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() > 0 || out_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drained", exp_q.size(), 0);
    endtask

    task automatic u_op(input logic [W-1:0] x, input logic [W-1:0] y);
        int h, t;
        t = 0;
        @(negedge clk);
        u_in_x = x; u_in_y = y; u_in_valid = 1'b1;
        while (!u_in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!u_in_ready) begin
            fail("u handshake timeout");
            u_in_valid = 1'b0;
            return;
        end
        h = cyc;
        @(posedge clk);
        #1;
        u_in_valid = 1'b0;
        @(negedge clk);
        check("u_clr", u_spm_clr, 1);
        check("u_spm_y_clear", u_spm_y, 0);
        for (int c = 0; c < 2*W + LAT; c++) begin
            @(negedge clk);
            check($sformatf("u_spm_y_cnt%0d", c), u_spm_y, longint'((y >> c) & 8'd1));
        end
        t = 0;
        while (!u_out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!u_out_valid) begin
            fail("u out_valid timeout");
            return;
        end
        check("u_latency", cyc - h, LATENCY);
        check("u_product", u_out_prod, ref_mul_u(x, y));
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin : main
        int hc, prev_hc, t;
        logic [W-1:0] nx, ny;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_prod", out_prod, 0);
        check("rst_spm_x", spm_x, 0);
        check("rst_spm_y", spm_y, 0);
        check("rst_spm_clr", spm_clr, 0);
        check("rst_u_in_ready", u_in_ready, 1);

        send(8'hFD, 8'h05, hc);
        send(8'h80, 8'h80, hc);
        send(8'h7F, 8'h81, hc);
        send(8'h00, 8'hFF, hc);
        drain();

        // Backpressure: stall in DONE while a new operand waits
        out_ready = 1'b0;
        send(W'($urandom), W'($urandom), hc);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) fail("stall out_valid timeout");
        nx = W'($urandom); ny = W'($urandom);
        in_x = nx; in_y = ny; in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b1;
        send(nx, ny, hc);
        check("accept_to_next", hc - acc_cyc, 1);
        drain();

        // Reset while RUN is at cnt=5
        send(W'($urandom), W'($urandom), hc);
        repeat (6) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_prod", out_prod, 0);
        send(8'h03, 8'h04, hc);
        drain();

        prev_hc = 0;
        for (int i = 0; i < 4; i++) begin
            send(W'($urandom), W'($urandom), hc);
            if (i > 0) check("b2b_period", hc - prev_hc, PERIOD);
            prev_hc = hc;
        end
        drain();

        u_op(8'hFF, 8'hFF);
        u_op(W'($urandom), W'($urandom));

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
